// File: rtl/bus_seq_unlock_pkg.sv
// bus_seq_unlock_pkg: FSM state encodings, LFSR taps, default key/window constants, key symbol unpacker
package bus_seq_unlock_pkg;
    localparam logic [1:0] S_LOCKED = 2'd0;
    localparam logic [1:0] S_ARMING = 2'd1;
    localparam logic [1:0] S_OPEN   = 2'd2;
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;
    localparam logic [23:0] DEF_KEY_SEQ = 24'hA5C396;
    localparam logic [1:0]  DEF_WIN_VAL = 2'b01;
    function automatic logic [7:0] key_sym(input logic [127:0] seq, input int len, input int kw, input int idx);
        logic [127:0] s;
        logic [8:0] m;
        s = seq >> (kw * (len - 1 - idx));
        m = (9'd1 << kw) - 9'd1;
        return s[7:0] & m[7:0];
    endfunction
endpackage

// File: rtl/bus_seq_unlock_lfsr.sv
// resp_lfsr: 8-bit Fibonacci LFSR, left shifting; i_load reloads SEED, i_step advances once, o_q current value
module resp_lfsr
    import bus_seq_unlock_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hB4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_step,
    output logic [7:0] o_q
);
    logic [7:0] r_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      r_q <= SEED;
        else if (i_load) r_q <= SEED;
        else if (i_step) r_q <= {r_q[6:0], ^(r_q & LFSR_TAPS)};
    assign o_q = r_q;
endmodule

// File: rtl/bus_seq_unlock.sv
// bus_seq_unlock: snoops window reads for a key sequence, then answers window reads with LFSR bits
// ports: clk/rst_n, bus_valid/bus_sel_n/bus_addr/bus_rd host access; rd_data/rd_oe response; unlocked, key_idx status
module bus_seq_unlock
    import bus_seq_unlock_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          WIN_HI     = 13,
    parameter int          WIN_LO     = 12,
    parameter              WIN_VAL    = DEF_WIN_VAL,
    parameter int          NIB_LO     = 4,
    parameter int          KEY_W      = 4,
    parameter int          KEY_LEN    = 6,
    parameter              KEY_SEQ    = DEF_KEY_SEQ,
    parameter logic [KEY_W-1:0] RELOCK_SYM = 4'hF,
    parameter int          RESP_W     = 1,
    parameter logic [7:0]  LFSR_SEED  = 8'hB4,
    parameter int          TIMEOUT    = 255,
    parameter bit          LOCK_ON_WR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_valid,
    input  logic              bus_sel_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rd,
    output logic [RESP_W-1:0] rd_data,
    output logic              rd_oe,
    output logic              unlocked,
    output logic [3:0]        key_idx
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int WIN_W = WIN_HI - WIN_LO + 1;
    localparam logic [127:0] KEY_ALL = 128'(KEY_SEQ);
    if (KEY_LEN * KEY_W != $bits(KEY_SEQ)) begin : g_bad_key_bits
        $fatal(1, "KEY_SEQ width does not match KEY_LEN*KEY_W");
    end
    if (KEY_LEN < 2 || KEY_LEN > 16) begin : g_bad_key_len
        $fatal(1, "KEY_LEN out of range 2..16");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $fatal(1, "LFSR_SEED must be non-zero");
    end
    logic [1:0]        r_state, w_state_n;
    logic [3:0]        r_idx, w_idx_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic              r_rd_oe, r_unlocked;
    logic [RESP_W-1:0] r_rd_data;
    logic              w_hit, w_rd, w_wr, w_load, w_resp;
    logic [KEY_W-1:0]  w_sym, w_key_cur, w_key0;
    logic [7:0]        w_lfsr;
    assign w_hit     = bus_valid & ~bus_sel_n & (bus_addr[WIN_HI:WIN_LO] == WIN_W'(WIN_VAL));
    assign w_rd      = w_hit & bus_rd;
    assign w_wr      = w_hit & ~bus_rd;
    assign w_sym     = bus_addr[NIB_LO+KEY_W-1:NIB_LO];
    assign w_key_cur = KEY_W'(key_sym(KEY_ALL, KEY_LEN, KEY_W, int'(r_idx)));
    assign w_key0    = KEY_W'(key_sym(KEY_ALL, KEY_LEN, KEY_W, 0));
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_cnt_n   = w_hit ? '0 : r_cnt;
        w_load    = 1'b0;
        w_resp    = 1'b0;
        if (w_wr && LOCK_ON_WR) begin
            w_state_n = S_LOCKED;
            w_idx_n   = 4'd0;
        end else if (w_rd && r_state == S_OPEN) begin
            w_state_n = (w_sym == RELOCK_SYM) ? S_LOCKED : S_OPEN;
            w_resp    = (w_sym != RELOCK_SYM);
        end else if (w_rd) begin
            // a wrong symbol that is itself the first key symbol restarts at step 1
            if (w_sym == w_key_cur && r_idx == 4'(KEY_LEN - 1)) begin
                w_state_n = S_OPEN;
                w_idx_n   = 4'd0;
                w_load    = 1'b1;
            end else if (w_sym == w_key_cur) begin
                w_state_n = S_ARMING;
                w_idx_n   = r_idx + 4'd1;
            end else begin
                w_state_n = (w_sym == w_key0) ? S_ARMING : S_LOCKED;
                w_idx_n   = (w_sym == w_key0) ? 4'd1 : 4'd0;
            end
        end else if (!w_hit && r_state == S_ARMING) begin
            // the TIMEOUT-th consecutive idle cycle drops the partial sequence
            w_state_n = (r_cnt >= CNT_W'(TIMEOUT - 1)) ? S_LOCKED : S_ARMING;
            w_idx_n   = (r_cnt >= CNT_W'(TIMEOUT - 1)) ? 4'd0 : r_idx;
            w_cnt_n   = (r_cnt >= CNT_W'(TIMEOUT - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state    <= S_LOCKED;
            r_idx      <= 4'd0;
            r_cnt      <= '0;
            r_rd_oe    <= 1'b0;
            r_rd_data  <= '0;
            r_unlocked <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_cnt      <= w_cnt_n;
            r_rd_oe    <= w_resp;
            r_unlocked <= (w_state_n == S_OPEN);
            if (w_resp) r_rd_data <= w_lfsr[RESP_W-1:0];
        end
    resp_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_resp),
        .o_q    (w_lfsr)
    );
    assign rd_data  = r_rd_data;
    assign rd_oe    = r_rd_oe;
    assign unlocked = r_unlocked;
    assign key_idx  = r_idx;
endmodule

// File: tb/tb_bus_seq_unlock.sv
// tb_bus_seq_unlock: directed and random bus accesses checked against a behavioural unlock model
module tb_bus_seq_unlock;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_valid = 1'b0;
    logic        bus_sel_n = 1'b1;
    logic [15:0] bus_addr = 16'h0;
    logic        bus_rd = 1'b0;
    logic        rd_data;
    logic        rd_oe;
    logic        unlocked;
    logic [3:0]  key_idx;
    int total = 0;
    int bad = 0;
    bit exp_q[$];
    int m_idx = 0;
    bit m_open = 0;
    int m_idle = 0;
    logic [7:0] m_lfsr = 8'hB4;
    int key[6] = '{10, 5, 12, 3, 9, 6};
    bus_seq_unlock dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_valid (bus_valid),
        .bus_sel_n (bus_sel_n),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .rd_data   (rd_data),
        .rd_oe     (rd_oe),
        .unlocked  (unlocked),
        .key_idx   (key_idx)
    );
    always #5 clk = ~clk;
    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [7:0] lfsr_next(logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction
    task automatic model(bit v, bit sn, logic [15:0] a, bit rd);
        bit hit;
        int sym;
        hit = v && !sn && a[13:12] == 2'b01;
        sym = int'(a[7:4]);
        if (hit && !rd) begin
            m_open = 0;
            m_idx = 0;
            m_idle = 0;
        end else if (hit) begin
            m_idle = 0;
            if (m_open) begin
                if (sym == 15) m_open = 0;
                else begin
                    exp_q.push_back(m_lfsr[0]);
                    m_lfsr = lfsr_next(m_lfsr);
                end
            end else if (sym == key[m_idx]) begin
                m_idx++;
                if (m_idx == 6) begin
                    m_open = 1;
                    m_idx = 0;
                    m_lfsr = 8'hB4;
                end
            end else m_idx = (sym == key[0]) ? 1 : 0;
        end else if (!m_open && m_idx > 0) begin
            m_idle++;
            if (m_idle >= 255) begin
                m_idx = 0;
                m_idle = 0;
            end
        end
    endtask
    task automatic cyc(bit v, bit sn, logic [15:0] a, bit rd);
        @(negedge clk);
        chk("key_idx", key_idx, m_idx);
        chk("unlocked", unlocked, m_open);
        bus_valid = v;
        bus_sel_n = sn;
        bus_addr = a;
        bus_rd = rd;
        model(v, sn, a, rd);
    endtask
    task automatic rd_sym(int s);
        cyc(1, 0, 16'h1000 | 16'(s << 4), 1);
    endtask
    task automatic idle(int n);
        repeat (n) cyc(0, 1, 16'h0, 1);
    endtask
    task automatic unlock_seq();
        for (int i = 0; i < 6; i++) rd_sym(key[i]);
    endtask
    initial forever begin
        @(posedge clk);
        #1;
        if (rd_oe) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_oe: got unexpected pulse, required none at %0t", $time);
            end else chk("rd_data", rd_data, exp_q.pop_front());
        end
    end
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset rd_oe", rd_oe, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset unlocked", unlocked, 0);
        chk("reset key_idx", key_idx, 0);
        unlock_seq();
        rd_sym(0);
        idle(2);
        rd_sym(10); rd_sym(5); rd_sym(12); rd_sym(7);
        rd_sym(10); rd_sym(5); rd_sym(10);
        for (int i = 1; i < 6; i++) rd_sym(key[i]);
        repeat (9) rd_sym(0);
        rd_sym(15);
        idle(2);
        rd_sym(10); rd_sym(5);
        idle(256);
        rd_sym(10); rd_sym(5);
        idle(254);
        rd_sym(12); rd_sym(3); rd_sym(9); rd_sym(6);
        rd_sym(15);
        rd_sym(10); rd_sym(5);
        cyc(1, 0, 16'h03C0, 1);
        cyc(1, 0, 16'h20C0, 1);
        cyc(1, 1, 16'h10C0, 1);
        cyc(0, 0, 16'h10C0, 1);
        rd_sym(12);
        cyc(1, 0, 16'h10A0, 0);
        idle(1);
        unlock_seq();
        cyc(1, 0, 16'h1000, 0);
        idle(1);
        unlock_seq();
        rd_sym(0);
        rd_sym(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus_valid = 1'b0;
        #1;
        chk("async rst rd_oe", rd_oe, 0);
        chk("async rst unlocked", unlocked, 0);
        chk("async rst key_idx", key_idx, 0);
        m_open = 0;
        m_idx = 0;
        m_idle = 0;
        m_lfsr = 8'hB4;
        @(negedge clk);
        rst_n = 1'b1;
        unlock_seq();
        repeat (4) rd_sym(2);
        repeat (800) begin
            int r;
            int s;
            logic [15:0] a;
            r = $urandom_range(0, 9);
            s = (r < 5) ? key[m_idx] : (r == 5) ? 15 : (r == 7) ? 10 : int'($urandom_range(0, 15));
            a = 16'(($urandom_range(0, 3) << 14) | (($urandom_range(0, 7) == 0 ? 2 : 1) << 12) | (s << 4) | $urandom_range(0, 15));
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, a, $urandom_range(0, 15) != 0);
        end
        idle(3);
        chk("pending responses", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
